// File: rtl/ss_dump_arb.sv
// Snapshot-port arbiter: CPU byte accesses always win; the dump engine streams a
// contiguous address range through a 2-entry FIFO so no read byte is ever dropped.
module ss_dump_arb #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdat,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdat,
  input  logic          dmp_start,
  input  logic          dmp_abort,
  input  logic [AW-1:0] dmp_base,
  input  logic [AW:0]   dmp_len,
  output logic          dmp_busy,
  output logic          dmp_done,
  output logic [DW-1:0] st_dat,
  output logic          st_vld,
  input  logic          st_rdy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          remain_q, remain_d;
  logic                 inflight_q, inflight_d;
  logic [1:0][DW-1:0]   fifo_q, fifo_d;
  logic                 fifo_wp_q, fifo_wp_d;
  logic                 fifo_rp_q, fifo_rp_d;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                 done_q, done_d;
  logic                 cpu_ack_q, cpu_ack_d;

  logic                 pop;
  logic                 issue;
  logic                 flush;
  logic [2:0]           occ;

  // Occupancy counts the byte leaving this cycle so a full-rate stream keeps one
  // read in flight every cycle without ever exceeding two buffered/outstanding.
  always_comb begin
    pop   = (fifo_cnt_q != 2'd0) && st_rdy;
    occ   = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
    issue = (state_q == StRun) && !cpu_req && !dmp_abort && (occ < 3'd2);
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    remain_d   = remain_q;
    done_d     = 1'b0;
    flush      = 1'b0;
    inflight_d = issue;
    cpu_ack_d  = cpu_req;
    fifo_d     = fifo_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q + 2'(inflight_q) - 2'(pop);

    if (inflight_q) begin
      fifo_d[fifo_wp_q] = mem_rdat;
      fifo_wp_d         = ~fifo_wp_q;
    end
    if (pop) begin
      fifo_rp_d = ~fifo_rp_q;
    end

    unique case (state_q)
      StIdle: begin
        if (dmp_start) begin
          if (dmp_len != '0) begin
            rd_ptr_d = dmp_base;
            remain_d = dmp_len;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (dmp_abort) begin
          flush = 1'b1;
        end else if (issue) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          remain_d = remain_q - (AW+1)'(1);
          if (remain_q == (AW+1)'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (dmp_abort) begin
          flush = 1'b1;
        end else if ((fifo_cnt_d == 2'd0) && !inflight_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort drops buffered bytes and the read currently on the memory bus.
    if (flush) begin
      state_d    = StIdle;
      inflight_d = 1'b0;
      fifo_cnt_d = 2'd0;
      fifo_wp_d  = 1'b0;
      fifo_rp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      fifo_q     <= '0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      done_q     <= 1'b0;
      cpu_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
      done_q     <= done_d;
      cpu_ack_q  <= cpu_ack_d;
    end
  end

  always_comb begin
    mem_addr = cpu_req ? cpu_addr : rd_ptr_q;
    mem_we   = cpu_req & cpu_we;
    mem_wdat = cpu_req ? cpu_wdat : '0;
    cpu_ack  = cpu_ack_q;
    cpu_rdat = cpu_ack_q ? mem_rdat : '0;
    dmp_busy = (state_q != StIdle);
    dmp_done = done_q;
    st_vld   = (fifo_cnt_q != 2'd0);
    st_dat   = fifo_q[fifo_rp_q];
  end

endmodule

// File: tb/tb_ss_dump_arb.sv
// Bench for ss_dump_arb: behavioural snapshot memory plus a stream scoreboard
// filled when a dump is started and drained on every stream handshake.
module tb_ss_dump_arb;

  logic        clk;
  logic        sys_rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdat;
  logic        cpu_ack;
  logic [7:0]  cpu_rdat;
  logic        dmp_start;
  logic        dmp_abort;
  logic [10:0] dmp_base;
  logic [11:0] dmp_len;
  logic        dmp_busy;
  logic        dmp_done;
  logic [7:0]  st_dat;
  logic        st_vld;
  logic        st_rdy;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdat;
  logic [7:0]  mem_rdat;

  logic [7:0]  mem [2048];
  logic [7:0]  exp_q [$];
  int          checks;
  int          errors;
  int          hs_cnt;
  bit          hold_prev;
  logic [7:0]  prev_dat;

  ss_dump_arb #(.AW(11), .DW(8)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdat  (cpu_wdat),
    .cpu_ack   (cpu_ack),
    .cpu_rdat  (cpu_rdat),
    .dmp_start (dmp_start),
    .dmp_abort (dmp_abort),
    .dmp_base  (dmp_base),
    .dmp_len   (dmp_len),
    .dmp_busy  (dmp_busy),
    .dmp_done  (dmp_done),
    .st_dat    (st_dat),
    .st_vld    (st_vld),
    .st_rdy    (st_rdy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdat  (mem_wdat),
    .mem_rdat  (mem_rdat)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Synchronous-read memory: read data appears one cycle after the address.
  always @(posedge clk) begin
    mem_rdat <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdat;
  end

  // Stream monitor: scoreboard compare, hold-under-backpressure, outstanding bound.
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (st_vld && st_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra got %02h required no byte", st_dat);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (st_dat !== e) begin
            errors++;
            $display("FAIL stream_data got %02h required %02h", st_dat, e);
          end
        end
        hs_cnt++;
      end
      if (hold_prev) begin
        checks++;
        if (st_vld !== 1'b1 || st_dat !== prev_dat) begin
          errors++;
          $display("FAIL stream_hold got vld=%b dat=%02h required vld=1 dat=%02h",
                   st_vld, st_dat, prev_dat);
        end
      end
      checks++;
      if (int'(dut.fifo_cnt_q) + int'(dut.inflight_q) > 2) begin
        errors++;
        $display("FAIL outstanding got %0d required <=2",
                 int'(dut.fifo_cnt_q) + int'(dut.inflight_q));
      end
    end
    hold_prev = sys_rst_n && st_vld && !st_rdy;
    prev_dat  = st_dat;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % 2048]);
  endtask

  task automatic start_dump(input int base, input int len);
    dmp_start = 1'b1;
    dmp_base  = 11'(base);
    dmp_len   = 12'(len);
    push_exp(base, len);
  endtask

  task automatic wait_done(input int max_cyc, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      dmp_start = 1'b0;
      dmp_abort = 1'b0;
      cpu_req   = 1'b0;
      @(negedge clk);
      if (dmp_done) begin
        got = 1'b1;
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({cpu_ack, dmp_busy, dmp_done, st_vld, mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000",
               {cpu_ack, dmp_busy, dmp_done, st_vld, mem_we});
    end
    checks++;
    if (cpu_rdat !== 8'h00 || st_dat !== 8'h00 || mem_wdat !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got rdat=%02h st=%02h wdat=%02h required 00",
               cpu_rdat, st_dat, mem_wdat);
    end
    checks++;
    if (mem_addr !== 11'h000) begin
      errors++;
      $display("FAIL reset_addr got %03h required 000", mem_addr);
    end
    step();
    sys_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dmp_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got %b required 0", dmp_busy);
    end
  endtask

  task automatic test_basic();
    hs_cnt = 0;
    st_rdy = 1'b1;
    step();
    start_dump(32'h010, 4);
    @(negedge clk);
    checks++;
    if (dmp_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_c0 got %b required 0", dmp_busy);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      dmp_start = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (mem_addr !== 11'h010 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL basic_first_addr got %03h we=%b required 010 we=0", mem_addr, mem_we);
        end
      end
      checks++;
      if (st_vld !== (c >= 3 && c <= 6)) begin
        errors++;
        $display("FAIL basic_vld c%0d got %b required %b", c, st_vld, (c >= 3 && c <= 6));
      end
      checks++;
      if (dmp_done !== (c == 7)) begin
        errors++;
        $display("FAIL basic_done c%0d got %b required %b", c, dmp_done, (c == 7));
      end
      checks++;
      if (dmp_busy !== (c <= 6)) begin
        errors++;
        $display("FAIL basic_busy c%0d got %b required %b", c, dmp_busy, (c <= 6));
      end
    end
    checks++;
    if (hs_cnt != 4) begin
      errors++;
      $display("FAIL basic_count got %0d required 4", hs_cnt);
    end
  endtask

  task automatic test_wrap();
    bit got;
    int cyc;
    logic [7:0] exp_rd;
    hs_cnt = 0;
    exp_rd = mem[0];
    step();
    start_dump(32'h7FE, 4);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 11'h000;
    step();
    dmp_start = 1'b0;
    cpu_req   = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdat !== exp_rd) begin
      errors++;
      $display("FAIL wrap_cpu_with_start got ack=%b rdat=%02h required ack=1 rdat=%02h",
               cpu_ack, cpu_rdat, exp_rd);
    end
    wait_done(20, got, cyc);
    checks++;
    if (!got || cyc != 6) begin
      errors++;
      $display("FAIL wrap_done got seen=%b cyc=%0d required seen=1 cyc=6", got, cyc);
    end
    checks++;
    if (hs_cnt != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count got %0d left %0d required 4 left 0", hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit got;
    got = 1'b0;
    hs_cnt = 0;
    step();
    st_rdy = 1'b1;
    start_dump(32'h2A0, 8);
    for (int c = 1; c <= 80 && !got; c++) begin
      step();
      dmp_start = 1'b0;
      st_rdy = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge clk);
      if (dmp_done) got = 1'b1;
    end
    st_rdy = 1'b1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_done got no done required done within 80 cycles");
    end
    checks++;
    if (hs_cnt != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d left %0d required 8 left 0", hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_cpu_priority();
    hs_cnt = 0;
    st_rdy = 1'b1;
    step();
    start_dump(32'h100, 16);
    for (int c = 1; c <= 22; c++) begin
      step();
      dmp_start = 1'b0;
      cpu_req   = (c == 5);
      cpu_we    = 1'b1;
      cpu_addr  = 11'h123;
      cpu_wdat  = 8'hA5;
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 11'h123 || mem_wdat !== 8'hA5) begin
          errors++;
          $display("FAIL cpu_grant got we=%b addr=%03h wdat=%02h required we=1 addr=123 wdat=a5",
                   mem_we, mem_addr, mem_wdat);
        end
      end
      if (c == 6) begin
        checks++;
        if (cpu_ack !== 1'b1) begin
          errors++;
          $display("FAIL cpu_wr_ack got %b required 1", cpu_ack);
        end
      end
      checks++;
      if (dmp_done !== (c == 20)) begin
        errors++;
        $display("FAIL cpu_dump_done c%0d got %b required %b", c, dmp_done, (c == 20));
      end
    end
    checks++;
    if (hs_cnt != 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cpu_dump_count got %0d left %0d required 16 left 0", hs_cnt, exp_q.size());
    end
    step();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 11'h123;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdat !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_readback got ack=%b rdat=%02h required ack=1 rdat=a5", cpu_ack, cpu_rdat);
    end
  endtask

  task automatic test_edge_cases();
    bit got;
    bit saw;
    int cyc;
    // Zero-length dump.
    hs_cnt = 0;
    step();
    start_dump(32'h040, 0);
    step();
    dmp_start = 1'b0;
    @(negedge clk);
    checks++;
    if (dmp_done !== 1'b1 || dmp_busy !== 1'b0 || st_vld !== 1'b0) begin
      errors++;
      $display("FAIL len0 got done=%b busy=%b vld=%b required 1 0 0", dmp_done, dmp_busy, st_vld);
    end
    step();
    @(negedge clk);
    checks++;
    if (dmp_done !== 1'b0 || st_vld !== 1'b0) begin
      errors++;
      $display("FAIL len0_after got done=%b vld=%b required 0 0", dmp_done, st_vld);
    end
    // Start while busy is ignored.
    step();
    start_dump(32'h200, 4);
    for (int c = 1; c <= 9; c++) begin
      step();
      dmp_start = (c == 2);
      dmp_base  = 11'h300;
      dmp_len   = 12'd8;
      @(negedge clk);
      checks++;
      if (dmp_done !== (c == 7)) begin
        errors++;
        $display("FAIL busy_start_done c%0d got %b required %b", c, dmp_done, (c == 7));
      end
    end
    checks++;
    if (dmp_busy !== 1'b0 || hs_cnt != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_start_ignored got busy=%b count=%0d required busy=0 count=4",
               dmp_busy, hs_cnt);
    end
    // Abort after three bytes.
    hs_cnt = 0;
    step();
    dmp_start = 1'b0;
    start_dump(32'h400, 8);
    for (int c = 1; c <= 5; c++) begin
      step();
      dmp_start = 1'b0;
      dmp_abort = (c == 5);
    end
    step();
    dmp_abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (st_vld !== 1'b0 || dmp_busy !== 1'b0 || hs_cnt != 3) begin
      errors++;
      $display("FAIL abort got vld=%b busy=%b count=%0d required 0 0 3", st_vld, dmp_busy, hs_cnt);
    end
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      if (dmp_done || st_vld) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL abort_quiet got done/vld activity required none");
    end
    hs_cnt = 0;
    step();
    start_dump(32'h500, 2);
    wait_done(20, got, cyc);
    checks++;
    if (!got || cyc != 5 || hs_cnt != 2) begin
      errors++;
      $display("FAIL abort_restart got seen=%b cyc=%0d count=%0d required 1 5 2", got, cyc, hs_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int cyc;
    hs_cnt = 0;
    st_rdy = 1'b1;
    step();
    start_dump(32'h600, 16);
    for (int c = 1; c <= 5; c++) begin
      step();
      dmp_start = 1'b0;
    end
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({cpu_ack, dmp_busy, dmp_done, st_vld, mem_we} !== 5'b0 || st_dat !== 8'h00 ||
        cpu_rdat !== 8'h00 || mem_addr !== 11'h000 || mem_wdat !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid got flags=%b st=%02h rdat=%02h addr=%03h required all 0",
               {cpu_ack, dmp_busy, dmp_done, st_vld, mem_we}, st_dat, cpu_rdat, mem_addr);
    end
    hs_cnt = 0;
    step();
    start_dump(32'h050, 4);
    wait_done(20, got, cyc);
    checks++;
    if (!got || cyc != 7 || hs_cnt != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_restart got seen=%b cyc=%0d count=%0d required 1 7 4",
               got, cyc, hs_cnt);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdat  = '0;
    dmp_start = 1'b0;
    dmp_abort = 1'b0;
    dmp_base  = '0;
    dmp_len   = '0;
    st_rdy    = 1'b1;
    checks    = 0;
    errors    = 0;
    hs_cnt    = 0;
    hold_prev = 1'b0;
    prev_dat  = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_cpu_priority();
    test_edge_cases();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
